// File: rtl/sd_dev_cmd_layer.sv
// Device-side SD command layer: frame/CRC check, user handoff, response send.
// Optional SD_DEV_CMD_QUEUE_EN adds a one-deep holding register for early commands.
module sd_dev_cmd_layer (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_crc_enable_flag,
    input  logic [15:0]  i_timeout,
    input  logic         i_phy_cmd_stb,
    input  logic [39:0]  i_phy_cmd,
    input  logic         i_phy_crc_bad,
    output logic         o_cmd_stb,
    output logic [5:0]   o_cmd_index,
    output logic [31:0]  o_cmd_arg,
    input  logic         i_rsp_stb,
    input  logic [1:0]   i_rsp_type,
    input  logic [5:0]   i_rsp_index,
    input  logic [127:0] i_rsp,
    output logic         o_phy_rsp_en,
    output logic [135:0] o_phy_rsp,
    output logic [7:0]   o_phy_rsp_len,
    input  logic         i_phy_rsp_finished,
    output logic         o_cmd_finished_en,
    output logic         o_busy,
    output logic         o_error_flag,
    output logic [7:0]   o_error
);

    typedef enum logic [1:0] {IDLE, WAIT_USER, SEND_RSP} state_t;

    state_t         r_state, w_state;
    logic [15:0]    r_timer, w_timer;
    logic [5:0]     r_cmd_index, w_cmd_index;
    logic [31:0]    r_cmd_arg, w_cmd_arg;
    logic           r_cmd_stb, w_cmd_stb;
    logic           r_rsp_en, w_rsp_en;
    logic [135:0]   r_rsp, w_rsp;
    logic [7:0]     r_rsp_len, w_rsp_len;
    logic           r_fin, w_fin;
    logic [7:0]     r_error, w_error;
    logic           r_error_flag, w_error_flag;
    logic           w_src_vld;
    logic [39:0]    w_src_cmd;
    logic           w_src_crc;
`ifdef SD_DEV_CMD_QUEUE_EN
    logic           r_q_valid, w_q_valid;
    logic [39:0]    r_q_cmd, w_q_cmd;
    logic           r_q_crc, w_q_crc;
`endif

    // Next-state and output decode; enable low overrides every other event
    always_comb begin
        w_state      = r_state;
        w_timer      = r_timer;
        w_cmd_index  = r_cmd_index;
        w_cmd_arg    = r_cmd_arg;
        w_cmd_stb    = 1'b0;
        w_rsp_en     = r_rsp_en;
        w_rsp        = r_rsp;
        w_rsp_len    = r_rsp_len;
        w_fin        = 1'b0;
        w_error      = r_error;
        w_error_flag = 1'b0;
        w_src_vld    = 1'b0;
        w_src_cmd    = i_phy_cmd;
        w_src_crc    = i_phy_crc_bad;
`ifdef SD_DEV_CMD_QUEUE_EN
        w_q_valid    = r_q_valid;
        w_q_cmd      = r_q_cmd;
        w_q_crc      = r_q_crc;
`endif
        if (!i_enable) begin
            w_state  = IDLE;
            w_rsp_en = 1'b0;
`ifdef SD_DEV_CMD_QUEUE_EN
            w_q_valid = 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
`ifdef SD_DEV_CMD_QUEUE_EN
                    // Held command goes first; a fresh strobe refills the slot
                    if (r_q_valid) begin
                        w_src_vld = 1'b1;
                        w_src_cmd = r_q_cmd;
                        w_src_crc = r_q_crc;
                        w_q_valid = i_phy_cmd_stb;
                        if (i_phy_cmd_stb) begin
                            w_q_cmd = i_phy_cmd;
                            w_q_crc = i_phy_crc_bad;
                        end
                    end else begin
                        w_src_vld = i_phy_cmd_stb;
                    end
`else
                    w_src_vld = i_phy_cmd_stb;
`endif
                    if (w_src_vld) begin
                        if (w_src_cmd[39:38] != 2'b01) begin
                            w_error      = 8'h03;
                            w_error_flag = 1'b1;
                        end else if (i_crc_enable_flag && w_src_crc) begin
                            w_error      = 8'h01;
                            w_error_flag = 1'b1;
                        end else begin
                            w_cmd_index = w_src_cmd[37:32];
                            w_cmd_arg   = w_src_cmd[31:0];
                            w_error     = 8'h00;
                            w_cmd_stb   = 1'b1;
                            w_timer     = 16'd0;
                            w_state     = WAIT_USER;
                        end
                    end
                end
                WAIT_USER: begin
                    w_timer = r_timer + 16'd1;
                    if (i_rsp_stb) begin
                        if (i_rsp_type == 2'd0) begin
                            w_fin   = 1'b1;
                            w_state = IDLE;
                        end else if (i_rsp_type == 2'd2) begin
                            w_rsp     = {2'b00, 6'h3F, i_rsp};
                            w_rsp_len = 8'd136;
                            w_rsp_en  = 1'b1;
                            w_state   = SEND_RSP;
                        end else begin
                            w_rsp     = {96'b0, 2'b00, i_rsp_index, i_rsp[31:0]};
                            w_rsp_len = 8'd40;
                            w_rsp_en  = 1'b1;
                            w_state   = SEND_RSP;
                        end
                    end else if (i_timeout != 16'd0 && r_timer >= i_timeout) begin
                        w_error      = 8'h02;
                        w_error_flag = 1'b1;
                        w_state      = IDLE;
                    end
                end
                SEND_RSP: begin
                    if (i_phy_rsp_finished) begin
                        w_rsp_en = 1'b0;
                        w_fin    = 1'b1;
                        w_state  = IDLE;
                    end
                end
                default: w_state = IDLE;
            endcase
            // Commands that arrive while a transaction is in flight
            if (r_state != IDLE && i_phy_cmd_stb) begin
`ifdef SD_DEV_CMD_QUEUE_EN
                if (r_q_valid) begin
                    w_error      = 8'h04;
                    w_error_flag = 1'b1;
                end else begin
                    w_q_valid = 1'b1;
                    w_q_cmd   = i_phy_cmd;
                    w_q_crc   = i_phy_crc_bad;
                end
`else
                w_error      = 8'h04;
                w_error_flag = 1'b1;
`endif
            end
        end
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_timer      <= 16'd0;
            r_cmd_index  <= 6'd0;
            r_cmd_arg    <= 32'd0;
            r_cmd_stb    <= 1'b0;
            r_rsp_en     <= 1'b0;
            r_rsp        <= 136'd0;
            r_rsp_len    <= 8'd40;
            r_fin        <= 1'b0;
            r_error      <= 8'h00;
            r_error_flag <= 1'b0;
`ifdef SD_DEV_CMD_QUEUE_EN
            r_q_valid    <= 1'b0;
            r_q_cmd      <= 40'd0;
            r_q_crc      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_timer      <= w_timer;
            r_cmd_index  <= w_cmd_index;
            r_cmd_arg    <= w_cmd_arg;
            r_cmd_stb    <= w_cmd_stb;
            r_rsp_en     <= w_rsp_en;
            r_rsp        <= w_rsp;
            r_rsp_len    <= w_rsp_len;
            r_fin        <= w_fin;
            r_error      <= w_error;
            r_error_flag <= w_error_flag;
`ifdef SD_DEV_CMD_QUEUE_EN
            r_q_valid    <= w_q_valid;
            r_q_cmd      <= w_q_cmd;
            r_q_crc      <= w_q_crc;
`endif
        end
    end

    assign o_cmd_stb         = r_cmd_stb;
    assign o_cmd_index       = r_cmd_index;
    assign o_cmd_arg         = r_cmd_arg;
    assign o_phy_rsp_en      = r_rsp_en;
    assign o_phy_rsp         = r_rsp;
    assign o_phy_rsp_len     = r_rsp_len;
    assign o_cmd_finished_en = r_fin;
    assign o_busy            = (r_state != IDLE);
    assign o_error_flag      = r_error_flag;
    assign o_error           = r_error;

endmodule

// File: tb/tb_sd_dev_cmd_layer.sv
// Self-checking bench for sd_dev_cmd_layer: directed scenarios plus a
// randomized transaction stream checked against a transaction-level model.
module tb_sd_dev_cmd_layer;

    logic         clk;
    logic         rst;
    logic         i_enable;
    logic         i_crc_enable_flag;
    logic [15:0]  i_timeout;
    logic         i_phy_cmd_stb;
    logic [39:0]  i_phy_cmd;
    logic         i_phy_crc_bad;
    logic         o_cmd_stb;
    logic [5:0]   o_cmd_index;
    logic [31:0]  o_cmd_arg;
    logic         i_rsp_stb;
    logic [1:0]   i_rsp_type;
    logic [5:0]   i_rsp_index;
    logic [127:0] i_rsp;
    logic         o_phy_rsp_en;
    logic [135:0] o_phy_rsp;
    logic [7:0]   o_phy_rsp_len;
    logic         i_phy_rsp_finished;
    logic         o_cmd_finished_en;
    logic         o_busy;
    logic         o_error_flag;
    logic [7:0]   o_error;

    int total = 0;
    int bad = 0;

    sd_dev_cmd_layer dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .i_crc_enable_flag  (i_crc_enable_flag),
        .i_timeout          (i_timeout),
        .i_phy_cmd_stb      (i_phy_cmd_stb),
        .i_phy_cmd          (i_phy_cmd),
        .i_phy_crc_bad      (i_phy_crc_bad),
        .o_cmd_stb          (o_cmd_stb),
        .o_cmd_index        (o_cmd_index),
        .o_cmd_arg          (o_cmd_arg),
        .i_rsp_stb          (i_rsp_stb),
        .i_rsp_type         (i_rsp_type),
        .i_rsp_index        (i_rsp_index),
        .i_rsp              (i_rsp),
        .o_phy_rsp_en       (o_phy_rsp_en),
        .o_phy_rsp          (o_phy_rsp),
        .o_phy_rsp_len      (o_phy_rsp_len),
        .i_phy_rsp_finished (i_phy_rsp_finished),
        .o_cmd_finished_en  (o_cmd_finished_en),
        .o_busy             (o_busy),
        .o_error_flag       (o_error_flag),
        .o_error            (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [39:0] f, input logic crcb);
        i_phy_cmd_stb = 1'b1;
        i_phy_cmd     = f;
        i_phy_crc_bad = crcb;
        tick();
        i_phy_cmd_stb = 1'b0;
        i_phy_crc_bad = 1'b0;
    endtask

    task automatic send_rsp(input logic [1:0] t, input logic [5:0] idx,
                            input logic [127:0] p);
        i_rsp_stb   = 1'b1;
        i_rsp_type  = t;
        i_rsp_index = idx;
        i_rsp       = p;
        tick();
        i_rsp_stb   = 1'b0;
    endtask

    task automatic phy_finish();
        i_phy_rsp_finished = 1'b1;
        tick();
        i_phy_rsp_finished = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
        total++; if (o_phy_rsp_en !== 1'b0) begin bad++; $display("FAIL reset_rsp_en got=%0h exp=0", o_phy_rsp_en); end
        total++; if (o_phy_rsp_len !== 8'd40) begin bad++; $display("FAIL reset_len got=%0d exp=40", o_phy_rsp_len); end
        total++; if (o_error !== 8'h00 || o_error_flag !== 1'b0) begin bad++; $display("FAIL reset_err got=%h/%0h exp=00/0", o_error, o_error_flag); end
        total++; if (o_cmd_stb !== 1'b0 || o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0h/%0h exp=0/0", o_cmd_stb, o_cmd_finished_en); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_short();
        send_cmd({2'b01, 6'd8, 32'h000001AA}, 1'b0);
        total++; if (o_cmd_stb !== 1'b1) begin bad++; $display("FAIL short_cmd_stb got=%0h exp=1", o_cmd_stb); end
        total++; if (o_cmd_index !== 6'd8 || o_cmd_arg !== 32'h1AA) begin bad++; $display("FAIL short_cmd got=%0d/%h exp=8/1aa", o_cmd_index, o_cmd_arg); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL short_busy got=%0h exp=1", o_busy); end
        tick();
        total++; if (o_cmd_stb !== 1'b0) begin bad++; $display("FAIL short_stb_pulse got=%0h exp=0", o_cmd_stb); end
        send_rsp(2'd1, 6'd8, 128'h1AA);
        total++; if (o_phy_rsp_en !== 1'b1) begin bad++; $display("FAIL short_rsp_en got=%0h exp=1", o_phy_rsp_en); end
        total++; if (o_phy_rsp[39:0] !== 40'h08000001AA) begin bad++; $display("FAIL short_frame got=%h exp=08000001aa", o_phy_rsp[39:0]); end
        total++; if (o_phy_rsp_len !== 8'd40) begin bad++; $display("FAIL short_len got=%0d exp=40", o_phy_rsp_len); end
        repeat (3) tick();
        total++; if (o_phy_rsp_en !== 1'b1 || o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL short_hold got=%0h/%0h exp=1/0", o_phy_rsp_en, o_cmd_finished_en); end
        phy_finish();
        total++; if (o_phy_rsp_en !== 1'b0 || o_cmd_finished_en !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL short_finish got=%0h/%0h/%0h exp=0/1/0", o_phy_rsp_en, o_cmd_finished_en, o_busy); end
        tick();
        total++; if (o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL short_fin_pulse got=%0h exp=0", o_cmd_finished_en); end
    endtask

    task automatic test_long();
        logic [127:0] p;
        p = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
        send_cmd({2'b01, 6'd2, 32'h0}, 1'b0);
        total++; if (o_cmd_index !== 6'd2) begin bad++; $display("FAIL long_idx got=%0d exp=2", o_cmd_index); end
        send_rsp(2'd2, 6'd0, p);
        total++; if (o_phy_rsp[135:128] !== 8'h3F) begin bad++; $display("FAIL long_hdr got=%h exp=3f", o_phy_rsp[135:128]); end
        total++; if (o_phy_rsp[127:0] !== p) begin bad++; $display("FAIL long_body got=%h exp=%h", o_phy_rsp[127:0], p); end
        total++; if (o_phy_rsp_len !== 8'd136) begin bad++; $display("FAIL long_len got=%0d exp=136", o_phy_rsp_len); end
        phy_finish();
        total++; if (o_cmd_finished_en !== 1'b1) begin bad++; $display("FAIL long_fin got=%0h exp=1", o_cmd_finished_en); end
        tick();
    endtask

    task automatic test_crc();
        i_crc_enable_flag = 1'b1;
        send_cmd({2'b01, 6'd17, 32'h55}, 1'b1);
        total++; if (o_error !== 8'h01 || o_error_flag !== 1'b1) begin bad++; $display("FAIL crc_err got=%h/%0h exp=01/1", o_error, o_error_flag); end
        total++; if (o_cmd_stb !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL crc_reject got=%0h/%0h exp=0/0", o_cmd_stb, o_busy); end
        tick();
        total++; if (o_error_flag !== 1'b0) begin bad++; $display("FAIL crc_flag_pulse got=%0h exp=0", o_error_flag); end
        i_crc_enable_flag = 1'b0;
        send_cmd({2'b01, 6'd17, 32'h55}, 1'b1);
        total++; if (o_cmd_stb !== 1'b1 || o_error !== 8'h00 || o_error_flag !== 1'b0) begin bad++; $display("FAIL crc_off_accept got=%0h/%h/%0h exp=1/00/0", o_cmd_stb, o_error, o_error_flag); end
        send_rsp(2'd0, 6'd0, 128'd0);
        total++; if (o_cmd_finished_en !== 1'b1 || o_busy !== 1'b0 || o_phy_rsp_en !== 1'b0) begin bad++; $display("FAIL rsp_none got=%0h/%0h/%0h exp=1/0/0", o_cmd_finished_en, o_busy, o_phy_rsp_en); end
        i_crc_enable_flag = 1'b1;
        tick();
    endtask

    task automatic test_framing();
        send_cmd(40'h8000000000, 1'b1);
        total++; if (o_error !== 8'h03 || o_error_flag !== 1'b1) begin bad++; $display("FAIL frame_err got=%h/%0h exp=03/1", o_error, o_error_flag); end
        total++; if (o_cmd_stb !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL frame_reject got=%0h/%0h exp=0/0", o_cmd_stb, o_busy); end
        tick();
    endtask

    task automatic test_timeout();
        i_timeout = 16'd5;
        send_cmd({2'b01, 6'd9, 32'h1}, 1'b0);
        total++; if (o_cmd_stb !== 1'b1) begin bad++; $display("FAIL to_stb got=%0h exp=1", o_cmd_stb); end
        repeat (5) tick();
        total++; if (o_error_flag !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL to_early got=%0h/%0h exp=0/1", o_error_flag, o_busy); end
        tick();
        total++; if (o_error !== 8'h02 || o_error_flag !== 1'b1) begin bad++; $display("FAIL to_err got=%h/%0h exp=02/1", o_error, o_error_flag); end
        total++; if (o_busy !== 1'b0 || o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h/%0h exp=0/0", o_busy, o_cmd_finished_en); end
        i_timeout = 16'd0;
        tick();
    endtask

    task automatic test_overrun();
        send_cmd({2'b01, 6'd3, 32'h0}, 1'b0);
        send_rsp(2'd1, 6'd3, 128'h12345678);
        send_cmd({2'b01, 6'd7, 32'hCAFE}, 1'b0);
`ifdef SD_DEV_CMD_QUEUE_EN
        total++; if (o_error_flag !== 1'b0) begin bad++; $display("FAIL q_capture got=%0h exp=0", o_error_flag); end
        send_cmd({2'b01, 6'd12, 32'hBEEF}, 1'b0);
        total++; if (o_error !== 8'h04 || o_error_flag !== 1'b1) begin bad++; $display("FAIL q_full got=%h/%0h exp=04/1", o_error, o_error_flag); end
        phy_finish();
        total++; if (o_cmd_finished_en !== 1'b1 || o_cmd_stb !== 1'b0) begin bad++; $display("FAIL q_fin got=%0h/%0h exp=1/0", o_cmd_finished_en, o_cmd_stb); end
        tick();
        total++; if (o_cmd_stb !== 1'b1 || o_cmd_index !== 6'd7 || o_cmd_arg !== 32'hCAFE) begin bad++; $display("FAIL q_replay got=%0h/%0d/%h exp=1/7/cafe", o_cmd_stb, o_cmd_index, o_cmd_arg); end
        send_rsp(2'd0, 6'd0, 128'd0);
        total++; if (o_cmd_finished_en !== 1'b1) begin bad++; $display("FAIL q_done got=%0h exp=1", o_cmd_finished_en); end
`else
        total++; if (o_error !== 8'h04 || o_error_flag !== 1'b1) begin bad++; $display("FAIL ovr_err got=%h/%0h exp=04/1", o_error, o_error_flag); end
        total++; if (o_phy_rsp_en !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL ovr_state got=%0h/%0h exp=1/1", o_phy_rsp_en, o_busy); end
        phy_finish();
        total++; if (o_cmd_finished_en !== 1'b1) begin bad++; $display("FAIL ovr_fin got=%0h exp=1", o_cmd_finished_en); end
        tick();
        total++; if (o_cmd_stb !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL ovr_dropped got=%0h/%0h exp=0/0", o_cmd_stb, o_busy); end
`endif
        tick();
    endtask

    task automatic test_abort();
        send_cmd({2'b01, 6'd4, 32'h0}, 1'b0);
        send_rsp(2'd1, 6'd4, 128'hA5);
        i_enable = 1'b0;
        tick();
        total++; if (o_phy_rsp_en !== 1'b0 || o_busy !== 1'b0 || o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL en_abort got=%0h/%0h/%0h exp=0/0/0", o_phy_rsp_en, o_busy, o_cmd_finished_en); end
        send_cmd({2'b01, 6'd5, 32'h0}, 1'b0);
        total++; if (o_cmd_stb !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL en_ignore got=%0h/%0h exp=0/0", o_cmd_stb, o_busy); end
        i_enable = 1'b1;
        tick();
        send_cmd({2'b01, 6'd4, 32'h0}, 1'b0);
        send_rsp(2'd2, 6'd4, 128'hA5);
        rst = 1'b0;
        tick();
        total++; if (o_phy_rsp_en !== 1'b0 || o_busy !== 1'b0 || o_cmd_finished_en !== 1'b0) begin bad++; $display("FAIL rst_abort got=%0h/%0h/%0h exp=0/0/0", o_phy_rsp_en, o_busy, o_cmd_finished_en); end
        total++; if (o_phy_rsp_len !== 8'd40) begin bad++; $display("FAIL rst_len got=%0d exp=40", o_phy_rsp_len); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          sel;
            int          d;
            int          tmo;
            logic [5:0]  idx;
            logic [31:0] arg;
            logic        crc_en;
            logic        crcb;
            logic [1:0]  pre;
            logic        exp_acc;
            logic [7:0]  exp_err;
            logic [1:0]  rt;
            logic [5:0]  ridx;
            logic [127:0] pay;
            logic [135:0] exp_frame;
            logic [7:0]  exp_len;
            kind   = $urandom_range(0, 3);
            idx    = 6'($urandom);
            arg    = $urandom;
            crc_en = 1'($urandom_range(0, 1));
            sel    = $urandom_range(0, 2);
            pre    = (kind != 0) ? 2'b01 : (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
            crcb   = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
            exp_acc = (pre == 2'b01) && !(crc_en && crcb);
            exp_err = (pre != 2'b01) ? 8'h03 : (crc_en && crcb) ? 8'h01 : 8'h00;
            tmo    = $urandom_range(1, 6);
            i_timeout = (kind == 3) ? 16'(tmo) : 16'd0;
            i_crc_enable_flag = crc_en;
            send_cmd({pre, idx, arg}, crcb);
            total++; if (o_cmd_stb !== exp_acc || o_error !== exp_err || o_error_flag !== !exp_acc) begin bad++; $display("FAIL rnd_cmd n=%0d got=%0h/%h/%0h exp=%0h/%h/%0h", n, o_cmd_stb, o_error, o_error_flag, exp_acc, exp_err, !exp_acc); end
            if (exp_acc) begin
                total++; if (o_cmd_index !== idx || o_cmd_arg !== arg) begin bad++; $display("FAIL rnd_fields n=%0d got=%h/%h exp=%h/%h", n, o_cmd_index, o_cmd_arg, idx, arg); end
                if (kind == 3) begin
                    repeat (tmo) tick();
                    total++; if (o_error_flag !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL rnd_to_early n=%0d got=%0h/%0h exp=0/1", n, o_error_flag, o_busy); end
                    tick();
                    total++; if (o_error !== 8'h02 || o_error_flag !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL rnd_to n=%0d got=%h/%0h/%0h exp=02/1/0", n, o_error, o_error_flag, o_busy); end
                end else begin
                    d = $urandom_range(0, 3);
                    repeat (d) tick();
                    rt   = 2'($urandom_range(0, 3));
                    ridx = 6'($urandom);
                    pay  = {$urandom, $urandom, $urandom, $urandom};
                    exp_frame = (rt == 2'd2) ? {8'h3F, pay} : {96'd0, 2'b00, ridx, pay[31:0]};
                    exp_len   = (rt == 2'd2) ? 8'd136 : 8'd40;
                    send_rsp(rt, ridx, pay);
                    if (rt == 2'd0) begin
                        total++; if (o_cmd_finished_en !== 1'b1 || o_busy !== 1'b0 || o_phy_rsp_en !== 1'b0) begin bad++; $display("FAIL rnd_none n=%0d got=%0h/%0h/%0h exp=1/0/0", n, o_cmd_finished_en, o_busy, o_phy_rsp_en); end
                    end else begin
                        total++; if (o_phy_rsp_en !== 1'b1 || o_phy_rsp !== exp_frame || o_phy_rsp_len !== exp_len) begin bad++; $display("FAIL rnd_rsp n=%0d got=%0h/%h/%0d exp=1/%h/%0d", n, o_phy_rsp_en, o_phy_rsp, o_phy_rsp_len, exp_frame, exp_len); end
                        repeat ($urandom_range(0, 3)) tick();
                        total++; if (o_phy_rsp_en !== 1'b1 || o_phy_rsp !== exp_frame || o_phy_rsp_len !== exp_len) begin bad++; $display("FAIL rnd_hold n=%0d got=%0h/%0d exp=1/%0d", n, o_phy_rsp_en, o_phy_rsp_len, exp_len); end
                        phy_finish();
                        total++; if (o_cmd_finished_en !== 1'b1 || o_phy_rsp_en !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rnd_fin n=%0d got=%0h/%0h/%0h exp=1/0/0", n, o_cmd_finished_en, o_phy_rsp_en, o_busy); end
                    end
                end
            end
            tick();
        end
        i_timeout = 16'd0;
        i_crc_enable_flag = 1'b1;
    endtask

    initial begin
        rst                = 1'b0;
        i_enable           = 1'b1;
        i_crc_enable_flag  = 1'b1;
        i_timeout          = 16'd0;
        i_phy_cmd_stb      = 1'b0;
        i_phy_cmd          = 40'd0;
        i_phy_crc_bad      = 1'b0;
        i_rsp_stb          = 1'b0;
        i_rsp_type         = 2'd0;
        i_rsp_index        = 6'd0;
        i_rsp              = 128'd0;
        i_phy_rsp_finished = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_crc();
        test_framing();
        test_timeout();
        test_overrun();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_dev_cmd_layer.md
# sd_dev_cmd_layer

Device-side (card-end) SD command layer: receives 40-bit command frames from the device PHY, checks framing and CRC, presents each valid command to the device's register/function logic, and returns that logic's R1/R3/R6-style short (40-bit) or R2 long (136-bit) response to the PHY for transmission. It is the responder counterpart of the host command layer and sits between the device PHY and the card-emulation core.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (reset when rst == 0)
- i_enable  in  1  layer enable; low forces IDLE and ignores commands
- i_crc_enable_flag  in  1  when high, a PHY CRC failure rejects the command
- i_timeout  in  16  cycles allowed for the user response; 0 = no timeout
- i_phy_cmd_stb  in  1  one-cycle pulse: i_phy_cmd valid
- i_phy_cmd  in  40  {start, tx, index[5:0], arg[31:0]}
- i_phy_crc_bad  in  1  CRC7 status, qualified by i_phy_cmd_stb
- o_cmd_stb  out  1  one-cycle pulse: new command on o_cmd_index/o_cmd_arg
- o_cmd_index  out  6  index of last accepted command
- o_cmd_arg  out  32  argument of last accepted command
- i_rsp_stb  in  1  one-cycle pulse: user response ready
- i_rsp_type  in  2  0 none, 1 short, 2 long, 3 treated as short
- i_rsp_index  in  6  index field for a short response (6'h3F for R3)
- i_rsp  in  128  response payload; short uses [31:0]
- o_phy_rsp_en  out  1  held high while PHY sends the response
- o_phy_rsp  out  136  response frame
- o_phy_rsp_len  out  8  40 short, 136 long
- i_phy_rsp_finished  in  1  PHY has finished sending
- o_cmd_finished_en  out  1  one-cycle pulse: transaction complete
- o_busy  out  1  high whenever state != IDLE
- o_error_flag  out  1  one-cycle pulse when o_error is written
- o_error  out  8  8'h00 none, 8'h01 CRC, 8'h02 timeout, 8'h03 framing, 8'h04 overrun

## Operation
- States: IDLE, WAIT_USER, SEND_RSP.
- IDLE + i_phy_cmd_stb: framing check i_phy_cmd[39:38] == 2'b01, else error 8'h03, stay IDLE. If i_crc_enable_flag && i_phy_crc_bad: error 8'h01, stay IDLE. Otherwise latch index/arg, clear o_error to 8'h00 (no flag pulse), pulse o_cmd_stb, clear timer, go to WAIT_USER. Framing check takes priority over CRC.
- WAIT_USER: 16-bit timer increments each cycle. On i_rsp_stb with type 0: pulse o_cmd_finished_en, go to IDLE. Types 1/3: o_phy_rsp = {96'b0, 2'b00, i_rsp_index, i_rsp[31:0]}, len 40. Type 2: o_phy_rsp = {2'b00, 6'h3F, i_rsp}, len 136. Assert o_phy_rsp_en, go to SEND_RSP. If i_timeout != 0 and the timer reaches i_timeout before i_rsp_stb: error 8'h02, go to IDLE, no finished pulse. When i_rsp_stb coincides with timeout, the response wins.
- SEND_RSP: hold o_phy_rsp_en and o_phy_rsp. On i_phy_rsp_finished: drop o_phy_rsp_en, pulse o_cmd_finished_en, go to IDLE.
- i_phy_cmd_stb outside IDLE is handled per Configuration.
- i_enable low: state goes to IDLE, o_phy_rsp_en 0, holding register cleared, no pulses. This takes priority over all other events in that cycle.
- rst low: state IDLE; all outputs 0 except o_phy_rsp_len = 40; holding register empty.

## Timing
- i_phy_cmd_stb at cycle N gives o_cmd_stb at N+1 (errors: o_error/o_error_flag at N+1).
- i_rsp_stb at M gives o_phy_rsp_en, o_phy_rsp and o_phy_rsp_len valid at M+1. Type 0 gives o_cmd_finished_en at M+1.
- i_phy_rsp_finished at K: o_phy_rsp_en low and o_cmd_finished_en high at K+1; IDLE at K+1.
- Timeout with i_timeout = T: error at T+1 cycles after o_cmd_stb.
- o_phy_rsp_len is registered with o_phy_rsp and is stable throughout SEND_RSP.

## Configuration
- SD_DEV_CMD_QUEUE_EN defined:
  - Adds a one-deep holding register. A command arriving outside IDLE is captured raw, with its CRC status.
  - On the first IDLE cycle, the held command is processed as if it had just arrived, with the same checks and o_cmd_stb one cycle later.
  - A command arriving while the register is full is dropped and reports error 8'h04.
  - A PHY strobe in IDLE while the register is full: the held entry is processed first and the new one is captured into the register.
- Undefined: any command outside IDLE is dropped and reports error 8'h04. State is unaffected.

## Test plan
- Command 8'h48 | {2'b01, 6'd8, 32'h000001AA}, CRC good -> o_cmd_stb at N+1, index 8, arg 32'h1AA. User short rsp index 8, payload 32'h1AA -> o_phy_rsp[39:0] = 40'h08000001AA, len 40. PHY finish -> finished pulse.
- CMD2 then long rsp with i_rsp = 128'hDEAD...BEEF -> o_phy_rsp[135:128] = 8'h3F, len 136.
- CRC bad with i_crc_enable_flag = 1 -> o_error 8'h01, flag pulse, no o_cmd_stb. Same command with flag 0 -> accepted.
- Frame 40'h8000000000 (start = 1) -> o_error 8'h03. i_timeout = 5 with no response -> o_error 8'h02 six cycles after o_cmd_stb, o_busy low.
- Command during SEND_RSP -> without macro, 8'h04 and dropped. With the macro, o_cmd_stb one cycle after the finished pulse; a third command in that window -> 8'h04.
- rst low or i_enable low mid-SEND_RSP -> o_phy_rsp_en 0 next cycle, IDLE, no finished pulse.
